// File: rtl/uart_mem_bridge_if.sv
// Word-wide valid/ready memory bus between the serial bridge and the upstream arbiter.
//   mem_valid  request held until mem_ready or abort
//   mem_ready  completion, one cycle
//   mem_addr   word address, [1:0] always 0
//   mem_wdata  write data
//   mem_wstrb  4'hF for a write, 4'h0 for a read
//   mem_rdata  read data, valid on the mem_ready cycle
interface uart_mem_bridge_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/uart_mem_bridge.sv
// Serial-driven debug/boot bus initiator. Parses 'W' A0..A3 D0..D3 and 'R' A0..A3 from uart_rx
// (all fields LSB first), performs one word access on the mem bus and replies through uart_tx:
// ACK (0x06) for a write, D0..D3 for a read, NAK (0x15) for an unknown command or a bus timeout.
//   clk, rst_n          clock, asynchronous active-low reset
//   rx_dout/rx_full     byte offered by uart_rx; rx_re pops it (1-cycle pulse)
//   tx_din/tx_we        byte pushed to uart_tx (1-cycle pulse); tx_empty = uart_tx can accept
//   bus                 mem bus master port
//   busy                high whenever the parser is not idle
module uart_mem_bridge #(
  parameter int unsigned RX_TIMEOUT  = 2500000,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                rx_dout,
  input  logic                      rx_full,
  output logic                      rx_re,
  output logic [7:0]                tx_din,
  output logic                      tx_we,
  input  logic                      tx_empty,
  uart_mem_bridge_if.master         bus,
  output logic                      busy
);

  localparam int unsigned RXW  = $clog2(RX_TIMEOUT + 1);
  localparam int unsigned BUSW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [RXW-1:0]  RX_LAST  = RXW'(RX_TIMEOUT - 1);
  localparam logic [BUSW-1:0] BUS_LAST = BUSW'(BUS_TIMEOUT - 1);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUS, S_TX, S_TX_GAP
  } state_t;

  state_t          state_q, state_d;
  logic            is_write_q, is_write_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [RXW-1:0]  rx_cnt_q, rx_cnt_d;
  logic [BUSW-1:0] bus_cnt_q, bus_cnt_d;
  logic            rx_re_q, rx_re_d;
  logic            tx_we_q, tx_we_d;
  logic [7:0]      tx_din_q, tx_din_d;
  logic            mem_valid_q, mem_valid_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic            busy_q, busy_d;
  logic [31:0]     tx_buf_q, tx_buf_d;
  logic [1:0]      tx_idx_q, tx_idx_d;
  logic [1:0]      tx_last_q, tx_last_d;
  logic            rx_take;

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    is_write_d  = is_write_q;
    byte_cnt_d  = byte_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    bus_cnt_d   = bus_cnt_q;
    rx_re_d     = 1'b0;
    tx_we_d     = 1'b0;
    tx_din_d    = tx_din_q;
    mem_valid_d = mem_valid_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    tx_buf_d    = tx_buf_q;
    tx_idx_d    = tx_idx_q;
    tx_last_d   = tx_last_q;

    // Accept a byte only while parsing; the rx_re_q guard keeps pops at least two cycles apart
    rx_take = rx_full && !rx_re_q && (state_q inside {S_IDLE, S_ADDR, S_DATA});
    if (rx_take) rx_re_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (rx_take) begin
          if (rx_dout == CMD_W || rx_dout == CMD_R) begin
            is_write_d = (rx_dout == CMD_W);
            byte_cnt_d = 2'd0;
            rx_cnt_d   = '0;
            state_d    = S_ADDR;
          end else begin
            tx_buf_d  = {24'h0, NAK};
            tx_idx_d  = 2'd0;
            tx_last_d = 2'd0;
            state_d   = S_TX;
          end
        end
      end

      S_ADDR, S_DATA: begin
        if (rx_take) begin
          rx_cnt_d = '0;
          if (state_q == S_ADDR) addr_d[{byte_cnt_q, 3'b000} +: 8] = rx_dout;
          else                   wdata_d[{byte_cnt_q, 3'b000} +: 8] = rx_dout;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (state_q == S_ADDR && is_write_q) begin
              state_d = S_DATA;
            end else begin
              wstrb_d   = is_write_q ? 4'hF : 4'h0;
              bus_cnt_d = '0;
              state_d   = S_BUS;
            end
          end
        end else if (rx_cnt_q == RX_LAST) begin
          // Inter-byte gap too long: drop the partial command silently
          state_d = S_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + RXW'(1);
        end
      end

      S_BUS: begin
        // valid rises the cycle after entry, so ready seen on the entry cycle is ignored
        if (!mem_valid_q) begin
          mem_valid_d = 1'b1;
          bus_cnt_d   = '0;
        end else if (bus.mem_ready) begin
          mem_valid_d = 1'b0;
          tx_idx_d    = 2'd0;
          if (is_write_q) begin
            tx_buf_d  = {24'h0, ACK};
            tx_last_d = 2'd0;
          end else begin
            tx_buf_d  = bus.mem_rdata;
            tx_last_d = 2'd3;
          end
          state_d = S_TX;
        end else if (bus_cnt_q == BUS_LAST) begin
          mem_valid_d = 1'b0;
          tx_buf_d    = {24'h0, NAK};
          tx_idx_d    = 2'd0;
          tx_last_d   = 2'd0;
          state_d     = S_TX;
        end else begin
          bus_cnt_d = bus_cnt_q + BUSW'(1);
        end
      end

      S_TX: begin
        if (tx_empty) begin
          tx_din_d = tx_buf_q[{tx_idx_q, 3'b000} +: 8];
          tx_we_d  = 1'b1;
          state_d  = S_TX_GAP;
        end
      end

      S_TX_GAP: begin
        // One idle cycle lets uart_tx drop tx_empty before the next byte is considered
        if (tx_idx_q == tx_last_q) begin
          state_d = S_IDLE;
        end else begin
          tx_idx_d = tx_idx_q + 2'd1;
          state_d  = S_TX;
        end
      end

      default: state_d = S_IDLE;
    endcase

    addr_d[1:0] = 2'b00;
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      is_write_q  <= 1'b0;
      byte_cnt_q  <= 2'd0;
      rx_cnt_q    <= '0;
      bus_cnt_q   <= '0;
      rx_re_q     <= 1'b0;
      tx_we_q     <= 1'b0;
      tx_din_q    <= 8'h00;
      mem_valid_q <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      wstrb_q     <= 4'h0;
      busy_q      <= 1'b0;
      tx_buf_q    <= 32'h0;
      tx_idx_q    <= 2'd0;
      tx_last_q   <= 2'd0;
    end else begin
      state_q     <= state_d;
      is_write_q  <= is_write_d;
      byte_cnt_q  <= byte_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      bus_cnt_q   <= bus_cnt_d;
      rx_re_q     <= rx_re_d;
      tx_we_q     <= tx_we_d;
      tx_din_q    <= tx_din_d;
      mem_valid_q <= mem_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      busy_q      <= busy_d;
      tx_buf_q    <= tx_buf_d;
      tx_idx_q    <= tx_idx_d;
      tx_last_q   <= tx_last_d;
    end
  end

  assign rx_re         = rx_re_q;
  assign tx_we         = tx_we_q;
  assign tx_din        = tx_din_q;
  assign busy          = busy_q;
  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// Bench for uart_mem_bridge: models uart_rx/uart_tx byte queues and a memory responder, and
// predicts accesses and reply bytes per command from the serial protocol rules.
`timescale 1ns/1ps
module tb_uart_mem_bridge;
  localparam int unsigned RX_TO  = 100;
  localparam int unsigned BUS_TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_dout = 8'h00;
  logic       rx_full = 1'b0;
  logic       rx_re;
  logic [7:0] tx_din;
  logic       tx_we;
  logic       tx_empty = 1'b1;
  logic       busy;

  uart_mem_bridge_if bus ();

  uart_mem_bridge #(.RX_TIMEOUT(RX_TO), .BUS_TIMEOUT(BUS_TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_dout(rx_dout), .rx_full(rx_full), .rx_re(rx_re),
    .tx_din(tx_din), .tx_we(tx_we), .tx_empty(tx_empty), .bus(bus), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  logic [7:0]  rxq[$];
  logic [7:0]  txq[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] acc_addr[$], acc_wdata[$];
  logic [3:0]  acc_wstrb[$];
  logic [31:0] exp_addr[$], exp_wdata[$];
  logic [3:0]  exp_wstrb[$];
  int          to_runs[$];
  int          exp_to = 0;
  logic [31:0] bus_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int          lat = 1;
  bit          tx_stall = 1'b0;
  int          tx_hold = 0;
  int          valid_run = 0;
  int          valid_seen = 0;
  bit          rx_re_prev = 1'b0;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h0001_0003) ^ 32'hC3A5_5A3C;
  endfunction

  // Environment: uart_rx queue, uart_tx sink and memory responder, all updated mid-cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 32'h0;
      valid_run     = 0;
      rx_re_prev    = 1'b0;
      tx_hold       = 0;
    end else begin
      if (rx_re) begin
        vectors++;
        if (rx_re_prev) begin
          errors++;
          $display("FAIL rx_re_pulse: rx_re=1 two cycles running at %0t, required single pulse", $time);
        end
        if (rxq.size() > 0) void'(rxq.pop_front());
      end
      rx_re_prev = rx_re;

      if (tx_we) begin
        vectors++;
        if (!tx_empty) begin
          errors++;
          $display("FAIL tx_we_stall: tx_we=1 while tx_empty=0 at %0t, required no push", $time);
        end
        txq.push_back(tx_din);
        tx_hold = int'($urandom_range(2, 0));
      end else if (tx_hold > 0) begin
        tx_hold--;
      end

      if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        vectors++;
        if (bus.mem_valid !== 1'b0) begin
          errors++;
          $display("FAIL valid_drop: mem_valid=%b after ready, required 0", bus.mem_valid);
        end
        valid_run = 0;
      end else if (bus.mem_valid) begin
        valid_seen++;
        if (valid_run == 0) begin
          cap_addr  = bus.mem_addr;
          cap_wdata = bus.mem_wdata;
          cap_wstrb = bus.mem_wstrb;
        end else begin
          vectors++;
          if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== {cap_addr, cap_wdata, cap_wstrb}) begin
            errors++;
            $display("FAIL bus_stable: addr/wdata/wstrb %h/%h/%h changed from %h/%h/%h while valid",
                     bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, cap_addr, cap_wdata, cap_wstrb);
          end
        end
        valid_run++;
        if (lat != 0 && valid_run == lat) begin
          bus.mem_ready = 1'b1;
          acc_addr.push_back(bus.mem_addr);
          acc_wdata.push_back(bus.mem_wdata);
          acc_wstrb.push_back(bus.mem_wstrb);
          if (bus.mem_wstrb == 4'hF) bus_mem[bus.mem_addr] = bus.mem_wdata;
          bus.mem_rdata = bus_mem.exists(bus.mem_addr) ? bus_mem[bus.mem_addr] : init_word(bus.mem_addr);
        end else begin
          bus.mem_rdata = $urandom;
        end
      end else if (valid_run != 0) begin
        to_runs.push_back(valid_run);
        valid_run = 0;
      end
    end
    rx_full  = (rxq.size() > 0);
    rx_dout  = (rxq.size() > 0) ? rxq[0] : 8'h00;
    tx_empty = !tx_stall && (tx_hold == 0);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: queue the command bytes and predict the access and the reply
  task automatic queue_cmd(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] wa;
    logic [31:0] v;
    wa = {addr[31:2], 2'b00};
    rxq.push_back(cmd);
    if (cmd == 8'h57 || cmd == 8'h52)
      for (int i = 0; i < 4; i++) rxq.push_back(addr[8*i +: 8]);
    if (cmd == 8'h57)
      for (int i = 0; i < 4; i++) rxq.push_back(data[8*i +: 8]);
    if (cmd != 8'h57 && cmd != 8'h52) begin
      exp_tx.push_back(8'h15);
    end else if (lat == 0) begin
      exp_tx.push_back(8'h15);
      exp_to++;
    end else begin
      exp_addr.push_back(wa);
      exp_wstrb.push_back(cmd == 8'h57 ? 4'hF : 4'h0);
      exp_wdata.push_back(cmd == 8'h57 ? data : 32'h0);
      if (cmd == 8'h57) begin
        ref_mem[wa] = data;
        exp_tx.push_back(8'h06);
      end else begin
        v = ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
        for (int i = 0; i < 4; i++) exp_tx.push_back(v[8*i +: 8]);
      end
    end
  endtask

  task automatic check_all(input string name);
    int n;
    n = 0;
    while ((txq.size() < exp_tx.size() || busy || rxq.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    cycles(3);
    vectors++;
    if (n >= 5000) begin
      errors++;
      $display("FAIL %s_done: no completion after %0d cycles, busy=%b", name, n, busy);
    end
    vectors++;
    if (txq.size() != exp_tx.size()) begin
      errors++;
      $display("FAIL %s_tx_count: got %0d bytes, required %0d", name, txq.size(), exp_tx.size());
    end
    for (int i = 0; i < txq.size() && i < exp_tx.size(); i++) begin
      vectors++;
      if (txq[i] !== exp_tx[i]) begin
        errors++;
        $display("FAIL %s_tx[%0d]: got %02h, required %02h", name, i, txq[i], exp_tx[i]);
      end
    end
    vectors++;
    if (acc_addr.size() != exp_addr.size()) begin
      errors++;
      $display("FAIL %s_acc_count: got %0d accesses, required %0d", name, acc_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < acc_addr.size() && i < exp_addr.size(); i++) begin
      vectors++;
      if (acc_addr[i] !== exp_addr[i] || acc_wstrb[i] !== exp_wstrb[i] ||
          (exp_wstrb[i] == 4'hF && acc_wdata[i] !== exp_wdata[i])) begin
        errors++;
        $display("FAIL %s_acc[%0d]: got addr %h wdata %h wstrb %h, required addr %h wdata %h wstrb %h",
                 name, i, acc_addr[i], acc_wdata[i], acc_wstrb[i], exp_addr[i], exp_wdata[i], exp_wstrb[i]);
      end
    end
    vectors++;
    if (to_runs.size() != exp_to) begin
      errors++;
      $display("FAIL %s_timeouts: got %0d bus timeouts, required %0d", name, to_runs.size(), exp_to);
    end
    foreach (to_runs[i]) begin
      vectors++;
      if (to_runs[i] != int'(BUS_TO)) begin
        errors++;
        $display("FAIL %s_valid_len: mem_valid high %0d cycles, required %0d", name, to_runs[i], BUS_TO);
      end
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: got %b, required 0", name, busy);
    end
    txq.delete(); exp_tx.delete();
    acc_addr.delete(); acc_wdata.delete(); acc_wstrb.delete();
    exp_addr.delete(); exp_wdata.delete(); exp_wstrb.delete();
    to_runs.delete(); exp_to = 0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({rx_re, tx_we, bus.mem_valid, busy} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes: rx_re/tx_we/mem_valid/busy=%b, required 0000",
               {rx_re, tx_we, bus.mem_valid, busy});
    end
    vectors++;
    if (tx_din !== 8'h00) begin
      errors++;
      $display("FAIL reset_tx_din: got %h, required 00", tx_din);
    end
    vectors++;
    if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: addr %h wdata %h, required 0/0", bus.mem_addr, bus.mem_wdata);
    end
    vectors++;
    if (bus.mem_wstrb !== 4'h0) begin
      errors++;
      $display("FAIL reset_wstrb: got %h, required 0", bus.mem_wstrb);
    end
  endtask

  task automatic test_write();
    lat = 2;
    queue_cmd(8'h57, 32'h0000_1000, 32'hDEAD_BEEF);
    check_all("write");
  endtask

  task automatic test_read();
    lat = 1;
    bus_mem[32'h0000_2004] = 32'h1234_5678;
    ref_mem[32'h0000_2004] = 32'h1234_5678;
    queue_cmd(8'h52, 32'h0000_2004, 32'h0);
    check_all("read");
  endtask

  task automatic test_bad_cmd();
    int vs;
    lat = 1;
    vs = valid_seen;
    queue_cmd(8'h41, 32'h0, 32'h0);
    check_all("bad_cmd");
    vectors++;
    if (valid_seen != vs) begin
      errors++;
      $display("FAIL bad_cmd_novalid: mem_valid seen %0d cycles, required 0", valid_seen - vs);
    end
    queue_cmd(8'h52, 32'h0000_2004, 32'h0);
    check_all("bad_cmd_read");
  endtask

  task automatic test_rx_timeout();
    int vs;
    int n;
    vs = valid_seen;
    rxq.push_back(8'h57); rxq.push_back(8'h00); rxq.push_back(8'h10);
    n = 0;
    while (rxq.size() != 0 && n < 100) begin @(negedge clk); n++; end
    cycles(90);
    vectors++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL rx_to_early: busy=%b 90 cycles after last byte, required 1", busy);
    end
    cycles(20);
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rx_to_idle: busy=%b 110 cycles after last byte, required 0", busy);
    end
    vectors++;
    if (txq.size() != 0 || valid_seen != vs) begin
      errors++;
      $display("FAIL rx_to_silent: %0d tx bytes, %0d valid cycles, required 0/0", txq.size(), valid_seen - vs);
    end
    lat = 1;
    queue_cmd(8'h52, 32'h0000_1000, 32'h0);
    check_all("rx_to_read");
  endtask

  task automatic test_bus_timeout();
    lat = 0;
    queue_cmd(8'h52, $urandom, 32'h0);
    check_all("bus_timeout");
    lat = 0;
    queue_cmd(8'h57, $urandom, $urandom);
    check_all("bus_timeout_w");
    lat = 1;
  endtask

  task automatic test_tx_stall();
    int n;
    lat = 3;
    tx_stall = 1'b1;
    queue_cmd(8'h52, 32'h0000_2004, 32'h0);
    n = 0;
    while (acc_addr.size() == 0 && n < 200) begin @(negedge clk); n++; end
    cycles(50);
    vectors++;
    if (txq.size() != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tx_stall_hold: %0d bytes sent, busy=%b while stalled, required 0/1", txq.size(), busy);
    end
    tx_stall = 1'b0;
    check_all("tx_stall");
  endtask

  task automatic test_reset_mid_bus();
    int n;
    int vs;
    lat = 0;
    rxq.push_back(8'h52);
    for (int i = 0; i < 4; i++) rxq.push_back(8'h40 + 8'(i));
    n = 0;
    while (bus.mem_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    cycles(4);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.mem_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_bus: mem_valid=%b busy=%b after reset, required 0/0", bus.mem_valid, busy);
    end
    cycles(3);
    rst_n = 1'b1;
    vs = valid_seen;
    cycles(40);
    vectors++;
    if (txq.size() != 0 || valid_seen != vs || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_no_reply: %0d tx bytes, %0d valid cycles, busy=%b, required 0/0/0",
               txq.size(), valid_seen - vs, busy);
    end
    txq.delete(); to_runs.delete(); rxq.delete();
    lat = 1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] pool [4];
    for (int i = 0; i < 4; i++) pool[i] = $urandom & 32'h000F_FFFF;
    for (int b = 0; b < 4; b++) begin
      lat = int'($urandom_range(4, 1));
      for (int k = 0; k < 6; k++) begin
        int sel;
        logic [31:0] a;
        logic [7:0] bad;
        sel = int'($urandom_range(9, 0));
        a = pool[$urandom_range(3, 0)] | 32'($urandom_range(3, 0));
        case ($urandom_range(3, 0))
          0: bad = 8'h41;
          1: bad = 8'h00;
          2: bad = 8'hFF;
          default: bad = 8'h53;
        endcase
        if (sel < 4)      queue_cmd(8'h57, a, $urandom);
        else if (sel < 8) queue_cmd(8'h52, a, 32'h0);
        else              queue_cmd(bad, a, 32'h0);
      end
      check_all("back_to_back");
    end
    lat = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    cycles(3);
    test_reset();
    rst_n = 1'b1;
    cycles(2);
    test_write();
    test_read();
    test_bad_cmd();
    test_rx_timeout();
    test_bus_timeout();
    test_tx_stall();
    test_reset_mid_bus();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
